mask_unit_read_response_collector: RTL and testbench
====================================================

# mask_unit_read_response_collector

Gathers lane read responses for one mask-unit read group and assembles them into a single result. Responses are tagged with the requester slot (`writeIndex`) and the byte position (`dataOffset`) assigned by the mask-unit read crossbar. The block sits downstream of that crossbar, on the lane read-data return path. It extracts the addressed element from each returned lane word, stores it in the slot's register, and presents the full group to the mask-unit datapath with a valid/ready handshake once every expected slot has arrived.

## Interface
- `LANES`, 4: number of lane response ports, and also the number of request slots.
- `DATA_W`, 32: lane word width in bits. Must be 32 because `dataOffset` is a 2-bit byte index.
- `clock` input 1: sole clock.
- `reset` input 1: reset, asynchronous and active-high.
- `issue_valid` input 1: group descriptor is valid.
- `issue_ready` output 1: block can accept a descriptor; equals (state==IDLE).
- `issue_bits_mask` input LANES: slots that will receive a response in this group.
- `issue_bits_sew` input 2: element width. 0 = 8-bit, 1 = 16-bit, 2 = 32-bit, 3 = treated as 2.
- `resp_<i>_valid` input 1, for i = 0..LANES-1: lane i returns read data. There is no ready; the block must always sink it.
- `resp_<i>_bits_data` input DATA_W: lane word.
- `resp_<i>_bits_writeIndex` input 2: destination slot.
- `resp_<i>_bits_dataOffset` input 2: byte offset of the element in the lane word.
- `out_valid` output 1: assembled group is available.
- `out_ready` input 1: consumer accepts the group.
- `out_bits_data` output LANES*DATA_W: slot k occupies bits [32k+31:32k], zero-extended.
- `out_bits_mask` output LANES: copy of the captured issue mask.
- `error` output 1: sticky protocol-violation flag, cleared only by reset.

## Operation
- **State machine:** IDLE, COLLECT, DRAIN.
- **IDLE:**
  - When `issue_valid` is high, capture `mask` and `sew` and clear the `filled` bits. Then:
    - mask != 0: go to COLLECT.
    - mask == 0: go to DRAIN with all slot data zero.
- **Response acceptance (COLLECT only):** for each port with `valid`, slot k = `writeIndex`.
  - Accept if `mask[k]` is set and `filled[k]` is clear. Write the extracted element to slot k and set `filled[k]`.
  - Two or more ports targeting the same slot in one cycle: the lowest-numbered port wins. The others are dropped and `error` is set.
  - Response to a slot already filled, or to a slot with `mask[k]` = 0: dropped, and `error` is set.
  - Any `resp_<i>_valid` while in IDLE or DRAIN: dropped, and `error` is set.
- **Extraction:** let w = data, o = dataOffset.
  - sew 0: w[8o+7:8o], zero-extended to 32 bits.
  - sew 1: w[16*o[1]+15:16*o[1]], zero-extended; o[0] is ignored.
  - sew 2 or 3: the whole of w; o is ignored.
- **Completion:** when (`filled` | accepted-this-cycle) == `mask`, move COLLECT to DRAIN at the next edge. Slot registers include the same-cycle writes.
- **DRAIN:**
  - `out_valid` = 1, and `out_bits` is held stable until `out_ready`.
  - On handshake, go to IDLE and clear `filled`.
  - Slot data is not cleared; unfilled slots read as whatever is in the register. This is defined only for mask == 0, where all slot data is zero.
- **Reset values:**
  - state = IDLE, so `issue_ready` = 1.
  - `filled`, the captured mask and sew, and all slot data = 0.
  - `out_valid` = 0, `out_bits_data` = 0, `out_bits_mask` = 0, `error` = 0.
- **Reset mid-operation:** asserting `reset` in any state returns the block to the reset values immediately and asynchronously. Partial groups are discarded.

## Timing
- Issue handshake at edge T: state is COLLECT (or DRAIN when mask == 0) from T+1.
- The first response can be accepted in the cycle after T.
- The last required response accepted at edge N: `out_valid` = 1 from N+1. The collector adds one cycle of latency.
- Out handshake at edge D: `issue_ready` = 1 from D+1. There is no same-cycle out→issue bypass, so the minimum group period is 3 cycles.
- `issue_ready` and `out_valid` are decoded from registered state only. There is no combinational path from any input to them.

## Test plan
- **Basic sew 8:** issue mask=4'b1111, sew=0.
  - Stimulus: lanes 0..3 all respond in one cycle with writeIndex 3,2,1,0, dataOffset 0,1,2,3, and data 0x44332211 on every lane.
  - Expected: next cycle `out_valid`=1 and `out_bits_data` = {0x11, 0x22, 0x33, 0x44} for slots 3..0, each zero-extended.
- **Staggered sew 16 with back-pressure:** issue mask=4'b0101, sew=1.
  - Stimulus: slot 0 gets data 0xBEEF1234 with dataOffset=2 at cycle 2, and slot 2 gets 0x0000CAFE with dataOffset=0 at cycle 5. Hold `out_ready`=0 for 3 cycles.
  - Expected: `out_valid` rises at cycle 6; slot0 = 0xBEEF and slot2 = 0xCAFE; `out_bits_data` is stable while stalled; `issue_ready` rises the cycle after the handshake.
- **Slot collision:** issue mask=4'b0001, sew=2.
  - Stimulus: lanes 1 and 3 both target writeIndex 0 in the same cycle.
  - Expected: lane 1's data is stored, `error`=1, and the group completes.
- **Illegal responses:** issue mask=4'b0011, sew=2.
  - Stimulus: a response to slot 2, then a second response to slot 0.
  - Expected: both are dropped, `error` latches to 1, and the group completes only after slot 1 arrives.
- **Empty mask and idle response:** issue mask=0.
  - Expected: `out_valid` one cycle later with all-zero data.
  - Stimulus: a response while IDLE.
  - Expected: `error`=1.
- **Async reset mid-COLLECT:** assert `reset` between clock edges after 2 of 4 slots are filled.
  - Expected: outputs go to their reset values immediately, `issue_ready`=1 after release, and the next group collects cleanly.

Source files
------------

// File: rtl/mask_unit_read_response_collector.sv
// mask_unit_read_response_collector
// Gathers the lane read responses of one mask-unit read group, extracts the
// addressed element from each lane word into its requester slot, and offers
// the assembled group downstream with a valid/ready handshake.
//
// Ports:
//   clock, reset               sole clock; asynchronous active-high reset
//   issue_valid/issue_ready    group descriptor handshake (ready only in IDLE)
//   issue_bits_mask            slots expected to receive a response
//   issue_bits_sew             element width: 0=8b, 1=16b, 2/3=32b
//   resp_<i>_*                 lane i read return (no back-pressure), i=0..3
//   out_valid/out_ready        assembled group handshake
//   out_bits_data              slot k in bits [32k+31:32k], zero-extended
//   out_bits_mask              captured issue mask
//   error                      sticky protocol-violation flag
module mask_unit_read_response_collector (
  input  logic         clock,
  input  logic         reset,
  input  logic         issue_valid,
  output logic         issue_ready,
  input  logic [3:0]   issue_bits_mask,
  input  logic [1:0]   issue_bits_sew,
  input  logic         resp_0_valid,
  input  logic [31:0]  resp_0_bits_data,
  input  logic [1:0]   resp_0_bits_writeIndex,
  input  logic [1:0]   resp_0_bits_dataOffset,
  input  logic         resp_1_valid,
  input  logic [31:0]  resp_1_bits_data,
  input  logic [1:0]   resp_1_bits_writeIndex,
  input  logic [1:0]   resp_1_bits_dataOffset,
  input  logic         resp_2_valid,
  input  logic [31:0]  resp_2_bits_data,
  input  logic [1:0]   resp_2_bits_writeIndex,
  input  logic [1:0]   resp_2_bits_dataOffset,
  input  logic         resp_3_valid,
  input  logic [31:0]  resp_3_bits_data,
  input  logic [1:0]   resp_3_bits_writeIndex,
  input  logic [1:0]   resp_3_bits_dataOffset,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_bits_data,
  output logic [3:0]   out_bits_mask,
  output logic         error
);

  localparam int unsigned LANES  = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t state, stateNext;

  logic [LANES-1:0]  filledQ, filledD;
  logic [LANES-1:0]  maskQ, maskD;
  logic [1:0]        sewQ, sewD;
  logic [DATA_W-1:0] slotQ [LANES];
  logic [DATA_W-1:0] slotD [LANES];
  logic              errorQ, errorD;
  logic              issueReadyQ, outValidQ;
  logic [LANES-1:0]  acceptD;

  // Lane ports gathered into arrays for uniform processing.
  logic [LANES-1:0]  respValid;
  logic [DATA_W-1:0] respData [LANES];
  logic [1:0]        respIdx  [LANES];
  logic [1:0]        respOff  [LANES];

  assign respValid  = {resp_3_valid, resp_2_valid, resp_1_valid, resp_0_valid};
  assign respData[0] = resp_0_bits_data;
  assign respData[1] = resp_1_bits_data;
  assign respData[2] = resp_2_bits_data;
  assign respData[3] = resp_3_bits_data;
  assign respIdx[0]  = resp_0_bits_writeIndex;
  assign respIdx[1]  = resp_1_bits_writeIndex;
  assign respIdx[2]  = resp_2_bits_writeIndex;
  assign respIdx[3]  = resp_3_bits_writeIndex;
  assign respOff[0]  = resp_0_bits_dataOffset;
  assign respOff[1]  = resp_1_bits_dataOffset;
  assign respOff[2]  = resp_2_bits_dataOffset;
  assign respOff[3]  = resp_3_bits_dataOffset;

  // Pick the addressed element out of a lane word and zero-extend it.
  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] w,
                                                input logic [1:0] o,
                                                input logic [1:0] sew);
    logic [DATA_W-1:0] sh;
    case (sew)
      2'd0: begin
        sh = w >> {o, 3'b000};
        return {24'b0, sh[7:0]};
      end
      2'd1: begin
        sh = w >> {o[1], 4'b0000};
        return {16'b0, sh[15:0]};
      end
      default: return w;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state, response acceptance and slot update.
  always_comb begin
    stateNext = state;
    filledD   = filledQ;
    maskD     = maskQ;
    sewD      = sewQ;
    errorD    = errorQ;
    acceptD   = '0;
    for (int unsigned k = 0; k < LANES; k++) slotD[k] = slotQ[k];

    case (state)
      IDLE: begin
        if (|respValid) errorD = 1'b1;
        if (issue_valid) begin
          maskD   = issue_bits_mask;
          sewD    = issue_bits_sew;
          filledD = '0;
          if (issue_bits_mask == '0) begin
            for (int unsigned k = 0; k < LANES; k++) slotD[k] = '0;
            stateNext = DRAIN;
          end else begin
            stateNext = COLLECT;
          end
        end
      end

      COLLECT: begin
        // Ports scanned in ascending order so the lowest port wins a slot.
        for (int unsigned i = 0; i < LANES; i++) begin
          if (respValid[i]) begin
            if (maskQ[respIdx[i]] && !filledQ[respIdx[i]] && !acceptD[respIdx[i]]) begin
              acceptD[respIdx[i]] = 1'b1;
              slotD[respIdx[i]]   = extract(respData[i], respOff[i], sewQ);
            end else begin
              errorD = 1'b1;
            end
          end
        end
        filledD = filledQ | acceptD;
        if ((filledQ | acceptD) == maskQ) stateNext = DRAIN;
      end

      DRAIN: begin
        if (|respValid) errorD = 1'b1;
        if (out_ready) begin
          filledD   = '0;
          stateNext = IDLE;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filledQ     <= '0;
      maskQ       <= '0;
      sewQ        <= '0;
      errorQ      <= 1'b0;
      issueReadyQ <= 1'b1;
      outValidQ   <= 1'b0;
      for (int unsigned k = 0; k < LANES; k++) slotQ[k] <= '0;
    end else begin
      filledQ     <= filledD;
      maskQ       <= maskD;
      sewQ        <= sewD;
      errorQ      <= errorD;
      issueReadyQ <= (stateNext == IDLE);
      outValidQ   <= (stateNext == DRAIN);
      for (int unsigned k = 0; k < LANES; k++) slotQ[k] <= slotD[k];
    end
  end

  assign issue_ready   = issueReadyQ;
  assign out_valid     = outValidQ;
  assign out_bits_mask = maskQ;
  assign error         = errorQ;

  for (genvar k = 0; k < LANES; k++) begin : g_out
    assign out_bits_data[k*DATA_W +: DATA_W] = slotQ[k];
  end

endmodule

// File: tb/tb_mask_unit_read_response_collector.sv
// Directed bench for mask_unit_read_response_collector: hand-computed
// expectations checked with immediate assertions after each clock edge.
module tb_mask_unit_read_response_collector;

  logic         clock = 1'b0;
  logic         reset;
  logic         issue_valid;
  logic         issue_ready;
  logic [3:0]   issue_bits_mask;
  logic [1:0]   issue_bits_sew;
  logic         rv [4];
  logic [31:0]  rd [4];
  logic [1:0]   ri [4];
  logic [1:0]   ro [4];
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_bits_data;
  logic [3:0]   out_bits_mask;
  logic         error;

  int vectors = 0;
  int miscompares = 0;

  mask_unit_read_response_collector dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_bits_mask(issue_bits_mask), .issue_bits_sew(issue_bits_sew),
    .resp_0_valid(rv[0]), .resp_0_bits_data(rd[0]),
    .resp_0_bits_writeIndex(ri[0]), .resp_0_bits_dataOffset(ro[0]),
    .resp_1_valid(rv[1]), .resp_1_bits_data(rd[1]),
    .resp_1_bits_writeIndex(ri[1]), .resp_1_bits_dataOffset(ro[1]),
    .resp_2_valid(rv[2]), .resp_2_bits_data(rd[2]),
    .resp_2_bits_writeIndex(ri[2]), .resp_2_bits_dataOffset(ro[2]),
    .resp_3_valid(rv[3]), .resp_3_bits_data(rd[3]),
    .resp_3_bits_writeIndex(ri[3]), .resp_3_bits_dataOffset(ro[3]),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bits_data(out_bits_data), .out_bits_mask(out_bits_mask),
    .error(error)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clrResp();
    for (int i = 0; i < 4; i++) begin
      rv[i] = 1'b0; rd[i] = '0; ri[i] = '0; ro[i] = '0;
    end
  endtask

  task automatic resp(input int lane, input logic [31:0] d,
                      input logic [1:0] idx, input logic [1:0] off);
    rv[lane] = 1'b1; rd[lane] = d; ri[lane] = idx; ro[lane] = off;
  endtask

  task automatic issue(input logic [3:0] m, input logic [1:0] s);
    issue_valid = 1'b1; issue_bits_mask = m; issue_bits_sew = s;
    step();
    issue_valid = 1'b0; issue_bits_mask = '0; issue_bits_sew = '0;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    step();
  endtask

  task automatic chkResetVals(input string tag);
    chk({tag, "_issue_ready"}, 128'(issue_ready), 128'(1));
    chk({tag, "_out_valid"},   128'(out_valid),   128'(0));
    chk({tag, "_data"},        out_bits_data,     128'(0));
    chk({tag, "_mask"},        128'(out_bits_mask), 128'(0));
    chk({tag, "_error"},       128'(error),       128'(0));
  endtask

  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_bits_mask = '0; issue_bits_sew = '0;
    out_ready = 1'b0;
    clrResp();
    #1;
    chkResetVals("reset");
    step(); step();
    reset = 1'b0;
    step();
    chkResetVals("post_reset");

    // Basic sew 8: all four slots in one cycle.
    issue(4'b1111, 2'd0);
    chk("t1_issue_ready_low", 128'(issue_ready), 128'(0));
    resp(0, 32'h44332211, 2'd3, 2'd0);
    resp(1, 32'h44332211, 2'd2, 2'd1);
    resp(2, 32'h44332211, 2'd1, 2'd2);
    resp(3, 32'h44332211, 2'd0, 2'd3);
    chk("t1_out_valid_pre", 128'(out_valid), 128'(0));
    step();
    clrResp();
    chk("t1_out_valid", 128'(out_valid), 128'(1));
    chk("t1_data", out_bits_data, {32'h11, 32'h22, 32'h33, 32'h44});
    chk("t1_mask", 128'(out_bits_mask), 128'(4'hF));
    chk("t1_error", 128'(error), 128'(0));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t1_out_valid_clr", 128'(out_valid), 128'(0));
    chk("t1_issue_ready", 128'(issue_ready), 128'(1));

    // Staggered sew 16 with back-pressure.
    issue(4'b0101, 2'd1);
    resp(0, 32'hBEEF1234, 2'd0, 2'd2);
    step();
    clrResp();
    chk("t2_partial_valid", 128'(out_valid), 128'(0));
    step(); step();
    chk("t2_wait_valid", 128'(out_valid), 128'(0));
    resp(2, 32'h0000CAFE, 2'd2, 2'd0);
    step();
    clrResp();
    for (int c = 0; c < 3; c++) begin
      chk("t2_stall_valid", 128'(out_valid), 128'(1));
      chk("t2_stall_slot0", 128'(out_bits_data[31:0]), 128'(32'h0000BEEF));
      chk("t2_stall_slot2", 128'(out_bits_data[95:64]), 128'(32'h0000CAFE));
      chk("t2_stall_ready", 128'(issue_ready), 128'(0));
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t2_issue_ready", 128'(issue_ready), 128'(1));
    chk("t2_out_valid_clr", 128'(out_valid), 128'(0));
    chk("t2_error", 128'(error), 128'(0));

    // Slot collision: lane 1 beats lane 3 for slot 0.
    issue(4'b0001, 2'd2);
    resp(1, 32'h11112222, 2'd0, 2'd1);
    resp(3, 32'h33334444, 2'd0, 2'd0);
    step();
    clrResp();
    chk("t3_out_valid", 128'(out_valid), 128'(1));
    chk("t3_slot0", 128'(out_bits_data[31:0]), 128'(32'h11112222));
    chk("t3_error", 128'(error), 128'(1));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    pulseReset();
    chk("t3_error_cleared", 128'(error), 128'(0));

    // Illegal responses: unmasked slot, then a repeat to a filled slot.
    issue(4'b0011, 2'd2);
    resp(0, 32'h0000DEAD, 2'd2, 2'd0);
    step();
    clrResp();
    chk("t4_unmasked_error", 128'(error), 128'(1));
    chk("t4_unmasked_valid", 128'(out_valid), 128'(0));
    resp(0, 32'h0000AAAA, 2'd0, 2'd0);
    step();
    resp(1, 32'h0000BBBB, 2'd0, 2'd0);
    step();
    clrResp();
    chk("t4_dup_valid", 128'(out_valid), 128'(0));
    resp(2, 32'h0000CCCC, 2'd1, 2'd3);
    step();
    clrResp();
    chk("t4_out_valid", 128'(out_valid), 128'(1));
    chk("t4_slots01", 128'(out_bits_data[63:0]), 128'({32'h0000CCCC, 32'h0000AAAA}));
    chk("t4_slot2_untouched", 128'(out_bits_data[95:64]), 128'(0));
    chk("t4_error", 128'(error), 128'(1));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    pulseReset();

    // Empty mask, then a response while idle.
    issue(4'b0000, 2'd0);
    chk("t5_out_valid", 128'(out_valid), 128'(1));
    chk("t5_data", out_bits_data, 128'(0));
    chk("t5_error", 128'(error), 128'(0));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t5_issue_ready", 128'(issue_ready), 128'(1));
    resp(0, 32'h12345678, 2'd0, 2'd0);
    step();
    clrResp();
    chk("t5_idle_error", 128'(error), 128'(1));
    pulseReset();

    // Asynchronous reset mid-COLLECT after two of four slots.
    issue(4'b1111, 2'd2);
    resp(0, 32'h00000001, 2'd0, 2'd0);
    resp(1, 32'h00000002, 2'd1, 2'd0);
    step();
    clrResp();
    chk("t6_partial_valid", 128'(out_valid), 128'(0));
    chk("t6_partial_data", out_bits_data, {64'h0, 32'h2, 32'h1});
    #2;
    reset = 1'b1;
    #1;
    chkResetVals("t6_async");
    #2;
    reset = 1'b0;
    step();
    chk("t6_release_ready", 128'(issue_ready), 128'(1));
    issue(4'b0011, 2'd0);
    resp(0, 32'h0000AB00, 2'd0, 2'd1);
    resp(1, 32'h000000CD, 2'd1, 2'd0);
    step();
    clrResp();
    chk("t6_out_valid", 128'(out_valid), 128'(1));
    chk("t6_data", out_bits_data, {32'h0, 32'h0, 32'hCD, 32'hAB});
    chk("t6_mask", 128'(out_bits_mask), 128'(4'b0011));
    chk("t6_error", 128'(error), 128'(0));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t6_done_ready", 128'(issue_ready), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
